fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the control/decode unit. Holds the program counter and fetches one 16-bit instruction at a time from instruction memory over a req/ack handshake. Presents the split instruction fields (opcode, register indices, immediate) to decode with a valid/ready handshake. Consumes the decoder's `ldpc` and `halt` outputs to redirect or stop the PC.

---
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches 16-bit words over a req/ack
// handshake and hands split instruction fields to decode under valid/ready.
module fetch_unit #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    output logic            ir_valid,
    input  logic            ir_ready,
    output logic [2:0]      opcode,
    output logic [1:0]      rd,
    output logic [1:0]      rs,
    output logic [1:0]      rt,
    output logic [6:0]      imm,
    output logic [PC_W-1:0] pc_out,
    input  logic            ldpc,
    input  logic [PC_W-1:0] target,
    input  logic            halt,
    output logic            halted,
    output logic [15:0]     retired
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_ISSUE  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t          state_q;
    logic            active_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [15:0]     ir_q;
    logic [PC_W-1:0] pc_out_q;
    logic [15:0]     retired_q;
    logic [15:0]     retired_d;
    logic            fetch_fire;
    logic            accept;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // active_q stays low for the first cycle after reset release so that the
    // handshake outputs come up one cycle later, decoded purely from flops.
    assign imem_req   = active_q && (state_q == S_FETCH);
    assign ir_valid   = active_q && (state_q == S_ISSUE);
    assign halted     = active_q && (state_q == S_HALTED);

    assign fetch_fire = imem_req && imem_ack;
    assign accept     = ir_valid && ir_ready;
    assign pc_d       = pc_q + PC_W'(1);
    assign retired_d  = sat_inc16(retired_q);

    assign imem_addr  = pc_q;
    assign pc_out     = pc_out_q;
    assign retired    = retired_q;

    assign opcode     = ir_q[15:13];
    assign rd         = ir_q[12:11];
    assign rs         = ir_q[10:9];
    assign rt         = ir_q[8:7];
    assign imm        = ir_q[6:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            active_q  <= 1'b0;
            pc_q      <= RESET_PC;
            ir_q      <= 16'h0000;
            pc_out_q  <= '0;
            retired_q <= 16'h0000;
        end else begin
            active_q <= 1'b1;
            case (state_q)
                S_FETCH: begin
                    if (fetch_fire) begin
                        ir_q     <= imem_rdata;
                        pc_out_q <= pc_q;
                        pc_q     <= pc_d;
                        state_q  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (accept) begin
                        retired_q <= retired_d;
                        // Halt takes priority; a halted core keeps its PC.
                        if (halt) begin
                            state_q <= S_HALTED;
                        end else begin
                            if (ldpc) begin
                                pc_q <= target;
                            end
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_HALTED: begin
                    state_q <= S_HALTED;
                end
                default: begin
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural instruction memory, scoreboard of
// expected (pc, instruction) pairs pushed at fetch and popped at issue.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        ir_valid;
    logic        ir_ready;
    logic [2:0]  opcode;
    logic [1:0]  rd;
    logic [1:0]  rs;
    logic [1:0]  rt;
    logic [6:0]  imm;
    logic [7:0]  pc_out;
    logic        ldpc;
    logic [7:0]  target;
    logic        halt;
    logic        halted;
    logic [15:0] retired;

    logic        ack_en;
    logic [15:0] mem [0:255];
    logic        saw4 = 1'b0;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] ir;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    fetch_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .opcode    (opcode),
        .rd        (rd),
        .rs        (rs),
        .rt        (rt),
        .imm       (imm),
        .pc_out    (pc_out),
        .ldpc      (ldpc),
        .target    (target),
        .halt      (halt),
        .halted    (halted),
        .retired   (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_ack   = ack_en;
    assign imem_rdata = mem[imem_addr];

    always @(posedge clk) begin
        if (imem_req && imem_addr == 8'h04) saw4 <= 1'b1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] pc);
        exp_t e;
        e.pc = pc;
        e.ir = mem[pc];
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        n_chk++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_valid"},  32'(ir_valid), 32'd1);
            chk({tag, "_pc_out"}, 32'(pc_out),   32'(e.pc));
            chk({tag, "_opcode"}, 32'(opcode),   32'(e.ir[15:13]));
            chk({tag, "_rd"},     32'(rd),       32'(e.ir[12:11]));
            chk({tag, "_rs"},     32'(rs),       32'(e.ir[10:9]));
            chk({tag, "_rt"},     32'(rt),       32'(e.ir[8:7]));
            chk({tag, "_imm"},    32'(imm),      32'(e.ir[6:0]));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h0313) ^ 16'h5A00;
        mem[0]    = 16'h0000;
        mem[1]    = 16'h0000;
        mem[2]    = 16'h0000;
        mem[3]    = 16'hB5AB;
        mem[8'h40] = 16'h1234;
        mem[8'h41] = 16'hE000;
        mem[8'hFF] = 16'h6C3D;

        rst_n    = 1'b0;
        ack_en   = 1'b1;
        ir_ready = 1'b1;
        ldpc     = 1'b0;
        halt     = 1'b0;
        target   = 8'h00;

        // Reset state
        cyc();
        cyc();
        chk("rst_req",     32'(imem_req),  32'd0);
        chk("rst_valid",   32'(ir_valid),  32'd0);
        chk("rst_halted",  32'(halted),    32'd0);
        chk("rst_retired", 32'(retired),   32'd0);
        chk("rst_pc_out",  32'(pc_out),    32'd0);
        chk("rst_addr",    32'(imem_addr), 32'd0);
        chk("rst_opcode",  32'(opcode),    32'd0);

        rst_n = 1'b1;
        cyc();

        // Sequential fetch of 0,1,2 with same-cycle ack and ready
        for (int i = 0; i < 3; i++) begin
            chk("seq_req",  32'(imem_req),  32'd1);
            chk("seq_addr", 32'(imem_addr), 32'(i));
            push_exp(8'(i));
            cyc();
            chk("seq_req_issue", 32'(imem_req), 32'd0);
            pop_check("seq");
            cyc();
        end
        chk("seq_retired", 32'(retired),   32'd3);
        chk("seq_addr3",   32'(imem_addr), 32'd3);

        // Field split and jump from PC 3 to 0x40
        push_exp(8'h03);
        cyc();
        pop_check("jmp");
        chk("split_opcode", 32'(opcode), 32'h5);
        chk("split_rd",     32'(rd),     32'h2);
        chk("split_rs",     32'(rs),     32'h2);
        chk("split_rt",     32'(rt),     32'h3);
        chk("split_imm",    32'(imm),    32'h2B);
        ldpc   = 1'b1;
        target = 8'h40;
        ack_en = 1'b0;
        cyc();
        ldpc = 1'b0;
        chk("jmp_req",  32'(imem_req),  32'd1);
        chk("jmp_addr", 32'(imem_addr), 32'h40);

        // Memory wait states
        for (int k = 0; k < 3; k++) begin
            chk("wait_req",   32'(imem_req),  32'd1);
            chk("wait_addr",  32'(imem_addr), 32'h40);
            chk("wait_valid", 32'(ir_valid),  32'd0);
            cyc();
        end
        ack_en   = 1'b1;
        ir_ready = 1'b0;
        push_exp(8'h40);
        cyc();

        // Backpressure with an ldpc pulse that must be ignored
        for (int k = 0; k < 2; k++) begin
            ldpc   = (k == 0);
            target = 8'h80;
            chk("bp_valid",  32'(ir_valid), 32'd1);
            chk("bp_pc_out", 32'(pc_out),   32'h40);
            chk("bp_opcode", 32'(opcode),   32'(mem[8'h40][15:13]));
            chk("bp_imm",    32'(imm),      32'(mem[8'h40][6:0]));
            cyc();
        end
        ldpc     = 1'b0;
        ir_ready = 1'b1;
        pop_check("bp");
        cyc();
        chk("bp_next_req",  32'(imem_req),  32'd1);
        chk("bp_next_addr", 32'(imem_addr), 32'h41);
        chk("bp_retired",   32'(retired),   32'd5);

        // Halt wins over a simultaneous ldpc
        push_exp(8'h41);
        cyc();
        pop_check("halt");
        halt   = 1'b1;
        ldpc   = 1'b1;
        target = 8'h10;
        cyc();
        halt = 1'b0;
        ldpc = 1'b0;
        chk("halt_halted",  32'(halted),   32'd1);
        chk("halt_req",     32'(imem_req), 32'd0);
        chk("halt_valid",   32'(ir_valid), 32'd0);
        chk("halt_retired", 32'(retired),  32'd6);
        repeat (4) cyc();
        chk("halt_sticky",     32'(halted),   32'd1);
        chk("halt_req_later",  32'(imem_req), 32'd0);
        chk("halt_ret_later",  32'(retired),  32'd6);
        chk("no_fetch_addr4",  32'(saw4),     32'd0);

        rst_n = 1'b0;
        cyc();
        chk("hrst_halted",  32'(halted),    32'd0);
        chk("hrst_req",     32'(imem_req),  32'd0);
        chk("hrst_retired", 32'(retired),   32'd0);
        chk("hrst_addr",    32'(imem_addr), 32'd0);
        rst_n = 1'b1;
        cyc();
        chk("restart_req",  32'(imem_req),  32'd1);
        chk("restart_addr", 32'(imem_addr), 32'd0);

        // PC wrap at 0xFF
        push_exp(8'h00);
        cyc();
        pop_check("pre_wrap");
        ldpc   = 1'b1;
        target = 8'hFF;
        cyc();
        ldpc = 1'b0;
        chk("wrap_addr_ff", 32'(imem_addr), 32'hFF);
        push_exp(8'hFF);
        cyc();
        pop_check("wrap");
        cyc();
        chk("wrap_req",     32'(imem_req),  32'd1);
        chk("wrap_addr_00", 32'(imem_addr), 32'h00);

        // Reset during a stalled fetch abandons it
        ack_en = 1'b0;
        mem[0] = 16'h7777;
        cyc();
        chk("stall_req",  32'(imem_req),  32'd1);
        chk("stall_addr", 32'(imem_addr), 32'h00);
        rst_n  = 1'b0;
        ack_en = 1'b1;
        cyc();
        chk("mrst_valid",  32'(ir_valid), 32'd0);
        chk("mrst_req",    32'(imem_req), 32'd0);
        chk("mrst_pc_out", 32'(pc_out),   32'd0);
        chk("mrst_opcode", 32'(opcode),   32'd0);
        chk("mrst_imm",    32'(imm),      32'd0);
        rst_n = 1'b1;
        cyc();
        chk("mrst_req2",  32'(imem_req),  32'd1);
        chk("mrst_addr2", 32'(imem_addr), 32'd0);
        push_exp(8'h00);
        cyc();
        pop_check("mrst");
        cyc();
        chk("mrst_retired", 32'(retired),   32'd1);
        chk("mrst_next",    32'(imem_addr), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
